// File: rtl/mouse_cursor_ctrl_if.sv
// Bus bundle for the mouse cursor controller: PS/2 byte input,
// frame pulse, and the sprite origin / status outputs.
interface mouse_cursor_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_start;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [2:0]  btn;
    logic        pkt_done;
    logic        pos_update;
    logic [7:0]  sync_err;

    modport master (
        output rx_data, rx_valid, frame_start,
        input  x0, y0, btn, pkt_done, pos_update, sync_err
    );

    modport slave (
        input  rx_data, rx_valid, frame_start,
        output x0, y0, btn, pkt_done, pos_update, sync_err
    );
endinterface

// File: rtl/mouse_cursor_ctrl.sv
// PS/2 mouse packet assembler with per-frame clamped sprite origin
// update, button latch and framing error counter.
module mouse_cursor_ctrl #(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int ACC_W   = 12,
    parameter int TIMEOUT = 100000
) (
    input logic clk,
    input logic rst_n,
    mouse_cursor_ctrl_if.slave bus
);
    typedef enum logic [1:0] {B0, B1, B2} state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT - 1);
    localparam logic [14:0] XM = 15'(X_MAX);
    localparam logic [14:0] YM = 15'(Y_MAX);
    localparam logic [10:0] XI = 11'(X_INIT);
    localparam logic [10:0] YI = 11'(Y_INIT);
    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                   r_state;
    logic [TO_W-1:0]          r_to;
    logic [7:0]               r_b0;
    logic [7:0]               r_b1;
    logic signed [ACC_W-1:0]  r_acc_x;
    logic signed [ACC_W-1:0]  r_acc_y;
    logic [10:0]              r_x0;
    logic [10:0]              r_y0;
    logic [2:0]               r_btn;
    logic                     r_pkt_done;
    logic                     r_pos_upd;
    logic [7:0]               r_sync;

    logic                     w_commit;
    logic                     w_to_hit;
    logic signed [8:0]        w_dx;
    logic signed [8:0]        w_dy;
    logic signed [ACC_W-1:0]  w_base_x;
    logic signed [ACC_W-1:0]  w_base_y;
    logic signed [ACC_W:0]    w_sum_x;
    logic signed [ACC_W:0]    w_sum_y;
    logic signed [ACC_W-1:0]  w_nacc_x;
    logic signed [ACC_W-1:0]  w_nacc_y;
    logic signed [15:0]       w_nx;
    logic signed [15:0]       w_ny;
    logic [10:0]              w_cx;
    logic [10:0]              w_cy;

    function automatic logic signed [ACC_W-1:0] sat(
        input logic signed [ACC_W:0] v
    );
        if (v[ACC_W] != v[ACC_W-1])
            return v[ACC_W] ? AMIN : AMAX;
        return v[ACC_W-1:0];
    endfunction

    assign w_commit = (r_state == B2) && bus.rx_valid;
    assign w_to_hit = (r_to == TO_LIM);

    // Overflow pins the delta to the extreme of its sign
    always_comb begin
        w_dx = {r_b0[4], r_b1};
        w_dy = {r_b0[5], bus.rx_data};
        if (r_b0[6]) w_dx = r_b0[4] ? 9'h100 : 9'h0FF;
        if (r_b0[7]) w_dy = r_b0[5] ? 9'h100 : 9'h0FF;
    end

    // A commit coinciding with frame_start lands in a fresh accumulator
    always_comb begin
        w_base_x = bus.frame_start ? '0 : r_acc_x;
        w_base_y = bus.frame_start ? '0 : r_acc_y;
        w_sum_x  = {w_base_x[ACC_W-1], w_base_x}
                 + {{(ACC_W-8){w_dx[8]}}, w_dx};
        w_sum_y  = {w_base_y[ACC_W-1], w_base_y}
                 - {{(ACC_W-8){w_dy[8]}}, w_dy};
        w_nacc_x = w_commit ? sat(w_sum_x) : w_base_x;
        w_nacc_y = w_commit ? sat(w_sum_y) : w_base_y;
    end

    always_comb begin
        w_nx = $signed({5'b0, r_x0})
             + {{(16-ACC_W){r_acc_x[ACC_W-1]}}, r_acc_x};
        w_ny = $signed({5'b0, r_y0})
             + {{(16-ACC_W){r_acc_y[ACC_W-1]}}, r_acc_y};
        w_cx = w_nx[10:0];
        w_cy = w_ny[10:0];
        if (w_nx[15])            w_cx = '0;
        else if (w_nx[14:0] > XM) w_cx = XM[10:0];
        if (w_ny[15])            w_cy = '0;
        else if (w_ny[14:0] > YM) w_cy = YM[10:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= B0;
            r_to       <= '0;
            r_b0       <= '0;
            r_b1       <= '0;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_x0       <= XI;
            r_y0       <= YI;
            r_btn      <= '0;
            r_pkt_done <= 1'b0;
            r_pos_upd  <= 1'b0;
            r_sync     <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            r_pos_upd  <= 1'b0;
            r_acc_x    <= w_nacc_x;
            r_acc_y    <= w_nacc_y;
            if (bus.frame_start) begin
                r_x0      <= w_cx;
                r_y0      <= w_cy;
                r_pos_upd <= 1'b1;
            end
            if (r_state == B0 || bus.rx_valid || w_to_hit)
                r_to <= '0;
            else
                r_to <= r_to + 1'b1;
            unique case (r_state)
                B0: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data[3]) begin
                            r_b0    <= bus.rx_data;
                            r_state <= B1;
                        end else if (r_sync != 8'hFF) begin
                            r_sync <= r_sync + 1'b1;
                        end
                    end
                end
                B1: begin
                    if (bus.rx_valid) begin
                        r_b1    <= bus.rx_data;
                        r_state <= B2;
                    end else if (w_to_hit) begin
                        r_state <= B0;
                    end
                end
                B2: begin
                    if (bus.rx_valid) begin
                        r_state    <= B0;
                        r_pkt_done <= 1'b1;
                        r_btn      <= r_b0[2:0];
                    end else if (w_to_hit) begin
                        r_state <= B0;
                    end
                end
                default: r_state <= B0;
            endcase
        end
    end

    assign bus.x0         = r_x0;
    assign bus.y0         = r_y0;
    assign bus.btn        = r_btn;
    assign bus.pkt_done   = r_pkt_done;
    assign bus.pos_update = r_pos_upd;
    assign bus.sync_err   = r_sync;
endmodule

// File: doc/mouse_cursor_ctrl.md
Name: mouse_cursor_ctrl

Overview:
- Upstream feeder of the mouse sprite stage. Assembles 3-byte PS/2 mouse packets from the byte receiver and accumulates the signed motion deltas.
- Once per frame, applies the accumulated motion to the sprite origin (x0, y0), clamped to the visible area.
- Also latches button state and counts framing errors.
- Origin changes only at frame_start, so the sprite never tears mid-frame.

Parameters:
- X_MAX, 639, largest legal x0
- Y_MAX, 479, largest legal y0
- X_INIT, 320, x0 after reset
- Y_INIT, 240, y0 after reset
- ACC_W, 12, width of the signed per-frame delta accumulators
- TIMEOUT, 100000, maximum clk cycles allowed between bytes of one packet

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received PS/2 byte
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- x0  out  11  sprite origin x, unsigned
- y0  out  11  sprite origin y, unsigned
- btn  out  3  {middle, right, left}, registered
- pkt_done  out  1  one-cycle pulse when a packet completes
- pos_update  out  1  one-cycle pulse, coincident with new x0/y0
- sync_err  out  8  saturating count of discarded first bytes

Behaviour:
- Reset (async, rst_n=0):
  - x0=X_INIT, y0=Y_INIT; btn, pkt_done, pos_update and sync_err = 0.
  - Accumulators = 0; FSM = B0; timeout counter = 0.
  - Reset mid-packet discards the partial packet.
- Packet format:
  - b0: [7]=Y ovf, [6]=X ovf, [5]=Y sign, [4]=X sign, [3]=1, [2:0]={M,R,L}.
  - b1 = X delta low byte; b2 = Y delta low byte.
  - dx = {b0[4], b1} and dy = {b0[5], b2}, each 9-bit two's complement.
- FSM states B0, B1, B2; bytes are consumed only when rx_valid=1.
  - B0: if rx_data[3]=1, store the byte and go to B1. Otherwise discard the byte, stay in B0, sync_err+1 (saturates at 255).
  - B1: store the X byte, go to B2.
  - B2: store the Y byte, go to B0. The packet is committed on this cycle; pkt_done and btn update on the next cycle edge (1-cycle latency).
  - Timeout: the counter clears on every rx_valid and increments in B1/B2. If it reaches TIMEOUT with no byte, go to B0 with no commit and no sync_err change. The counter is held at 0 in B0.
- Overflow handling:
  - X ovf=1 forces dx to +255 (sign 0) or −256 (sign 1).
  - Y ovf is handled the same way for dy.
- Commit:
  - acc_x += dx.
  - acc_y −= dy (PS/2 +Y is up; screen +y is down).
  - Both are saturating signed ACC_W adds, clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- Frame apply (cycle after frame_start):
  - nx = x0 + acc_x and ny = y0 + acc_y, computed at ≥13-bit signed width.
  - Clamp: <0 gives 0; >X_MAX gives X_MAX (Y_MAX for y).
  - x0 and y0 load the clamped values; pos_update=1 for that single cycle.
  - Accumulators clear.
  - pos_update pulses on every frame_start, even when both deltas are 0.
- Simultaneous frame_start and packet commit:
  - The apply uses the accumulator value before the commit.
  - The accumulator then loads the new packet's delta alone, so the packet applies next frame. No delta is lost or double-counted.
- rx_valid asserted in back-to-back cycles is legal; each cycle consumes one byte.
- x0/y0 change only on the pos_update cycle. btn changes only on the pkt_done cycle.

Test Plan:
- Reset release, then frame_start with no bytes → x0=320, y0=240; pos_update pulses one cycle after frame_start; btn=0.
- Bytes 0x09,0x0A,0x05 then frame_start → pkt_done pulses once; btn=3'b001; x0=330, y0=235.
- Bytes 0x19,0x00,0x00 (dx=−256) sent twice, then frame_start → x0 clamps to 0. Then 0x08,0xFF,0x00 ×3 and frame_start → x0=639.
- Stray 0x00 then 0x08,0x01,0x01 → sync_err=1 and the packet is still accepted. After a frame_start, x0 rises by 1 and y0 falls by 1.
- Byte 0x08, then a gap of TIMEOUT cycles, then 0x08,0x02,0x00 → only one packet commits; after frame_start, dx=+2 is applied.
- Third byte's rx_valid in the same cycle as frame_start → that frame applies the earlier accumulator only. The new delta appears after the next frame_start.
